// File: rtl/pong_pkg.sv
// pong_pkg: shared state type, default limits and small elaboration helpers
// for the score limit selector.
package pong_pkg;

    // Per-direction auto-repeat state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    localparam int          DEF_WIDTH        = 5;
    localparam int          DEF_MIN_VAL      = 1;
    localparam int          DEF_MAX_VAL      = 20;
    localparam int          DEF_INIT_VAL     = 1;
    localparam int unsigned DEF_REPEAT_DELAY = 50_000_000;
    localparam int unsigned DEF_REPEAT_RATE  = 10_000_000;

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0 .. n-1, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_limit_ctrl_btn_repeat.sv
// btn_repeat: one button direction -- 2-flop synchronizer, press/hold FSM
// with auto-repeat counter, and a single-cycle step request.
module btn_repeat
    import pong_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    input  logic lock_i,
    input  logic other_i,
    output logic level_o,
    output logic step_o
);

    localparam int unsigned CW = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

    logic          s1_q;
    logic          s2_q;
    logic          v1_q;
    logic          v2_q;
    logic          armed_q;
    rpt_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          go;
    logic          rel;

    // Synchronize the raw button; v*_q marks when s2_q holds a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            v1_q <= 1'b1;
            v2_q <= v1_q;
        end
    end

    // A press counts only when this button alone is held and lock is low.
    assign go      = s2_q & ~other_i & ~lock_i;
    assign rel     = v2_q & ~s2_q;
    assign level_o = s2_q;

    // Steps happen on the press itself and on each counter wrap.
    assign step_o = go & (((state_q == IDLE) & armed_q) |
                          ((state_q == DELAY) & (cnt_q == DLY_LAST)) |
                          ((state_q == REPEAT) & (cnt_q == RATE_LAST)));

    // Press FSM, repeat counter and the must-release-first flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= lock_i ? rel : (armed_q | rel);
            if (!go) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (armed_q) begin
                            state_q <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (step_o) begin
                            state_q <= REPEAT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    REPEAT: begin
                        cnt_q <= step_o ? '0 : cnt_q + CW'(1);
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/score_limit_ctrl.sv
// score_limit_ctrl: up/down score limit with hold-to-repeat buttons and lock.
// Define SCORE_LIMIT_WRAP_EN to wrap at the limits instead of saturating.
module score_limit_ctrl
    import pong_pkg::*;
#(
    parameter int          WIDTH        = DEF_WIDTH,
    parameter int          MIN_VAL      = DEF_MIN_VAL,
    parameter int          MAX_VAL      = DEF_MAX_VAL,
    parameter int          INIT_VAL     = DEF_INIT_VAL,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_btn,
    input  logic             dec_btn,
    input  logic             lock,
    output logic [WIDTH-1:0] value,
    output logic             at_min,
    output logic             at_max,
    output logic             changed
);

    if (!(MIN_VAL >= 0 && MIN_VAL <= INIT_VAL && INIT_VAL <= MAX_VAL &&
          WIDTH >= 1 && WIDTH <= 30 && MAX_VAL < (1 << WIDTH) &&
          REPEAT_DELAY >= 1 && REPEAT_RATE >= 1)) begin : g_bad_cfg
        $error("score_limit_ctrl: illegal parameter combination");
    end

    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);
    localparam logic INIT_AT_MIN = (INIT_VAL == MIN_VAL);
    localparam logic INIT_AT_MAX = (INIT_VAL == MAX_VAL);

`ifdef SCORE_LIMIT_WRAP_EN
    localparam logic [WIDTH-1:0] ABOVE_MAX = MIN_V;
    localparam logic [WIDTH-1:0] BELOW_MIN = MAX_V;
`else
    localparam logic [WIDTH-1:0] ABOVE_MAX = MAX_V;
    localparam logic [WIDTH-1:0] BELOW_MIN = MIN_V;
`endif

    logic             inc_lvl;
    logic             dec_lvl;
    logic             inc_step;
    logic             dec_step;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             at_min_q;
    logic             at_max_q;
    logic             changed_q;

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (inc_btn),
        .lock_i  (lock),
        .other_i (dec_lvl),
        .level_o (inc_lvl),
        .step_o  (inc_step)
    );

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (dec_btn),
        .lock_i  (lock),
        .other_i (inc_lvl),
        .level_o (dec_lvl),
        .step_o  (dec_step)
    );

    // Next value: one step at most per cycle, clamped or wrapped at limits.
    always_comb begin
        value_d = value_q;
        if (inc_step) begin
            value_d = (value_q == MAX_V) ? ABOVE_MAX : value_q + WIDTH'(1);
        end else if (dec_step) begin
            value_d = (value_q == MIN_V) ? BELOW_MIN : value_q - WIDTH'(1);
        end
    end

    // Flags come from value_d so they line up with the registered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= INIT_V;
            at_min_q  <= INIT_AT_MIN;
            at_max_q  <= INIT_AT_MAX;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            at_min_q  <= (value_d == MIN_V);
            at_max_q  <= (value_d == MAX_V);
            changed_q <= (value_d != value_q);
        end
    end

    assign value   = value_q;
    assign at_min  = at_min_q;
    assign at_max  = at_max_q;
    assign changed = changed_q;

endmodule
